// File: rtl/ads868x_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// ads868x_seq_ctrl : channel-scan SPI sequencer for ADS868x ADCs
// Revision 1.0
// ------------------------------------------------------------------------
module ads868x_seq_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 2,
  parameter int CSN_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              data_valid,
  output logic [2:0]        data_ch,
  output logic [DATA_W-1:0] data,
  output logic              csn,
  output logic              sclk,
  output logic              sdi,
  input  logic              sdo
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int GAP_W = (CSN_IDLE > 1) ? $clog2(CSN_IDLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSN_IDLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [4:0]        fall_cnt;
  logic [31:0]       tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [NUM_CH-1:0] mask_rem;
  logic [2:0]        cur_ch;
  logic [2:0]        prev_ch;
  logic              cur_nop;
  logic              first_frame;

  logic       div_done;
  logic       gap_done;
  logic       accept;
  logic       rise_evt;
  logic       fall_evt;
  logic       frame_end;
  logic       next_frame;
  logic [2:0] pick_start;
  logic [2:0] pick_rem;

  function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = 3'(i);
    end
  endfunction

  // Manual-channel-select command: 4'hC with ch[2] in bit 28, ch[1:0] below it.
  function automatic logic [31:0] frame_cmd(input logic [2:0] ch);
    frame_cmd = {3'b110, ch[2], ch[1:0], 26'd0};
  endfunction

  function automatic logic [NUM_CH-1:0] drop_ch(input logic [NUM_CH-1:0] m,
                                                input logic [2:0]        ch);
    drop_ch = m & ~(NUM_CH'(1) << ch);
  endfunction

  assign div_done   = (div_cnt == DIV_LAST);
  assign gap_done   = (gap_cnt == GAP_LAST);
  assign accept     = (state == IDLE) && start && (|ch_mask);
  assign rise_evt   = div_done && ((state == SETUP) || ((state == SHIFT) && !sclk));
  assign fall_evt   = div_done && (state == SHIFT) && sclk;
  assign frame_end  = fall_evt && (fall_cnt == 5'd31);
  assign next_frame = (state == GAP) && gap_done && !cur_nop;
  assign pick_start = lowest_ch(ch_mask);
  assign pick_rem   = lowest_ch(mask_rem);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SETUP;
      SETUP:   if (div_done)  state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = GAP;
      GAP:     if (gap_done)  state_nxt = cur_nop ? IDLE : SETUP;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      gap_cnt     <= '0;
      fall_cnt    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      mask_rem    <= '0;
      cur_ch      <= '0;
      prev_ch     <= '0;
      cur_nop     <= 1'b0;
      first_frame <= 1'b0;
      csn         <= 1'b1;
      sclk        <= 1'b0;
      sdi         <= 1'b0;
      data_valid  <= 1'b0;
      data_ch     <= '0;
      data        <= '0;
    end else begin
      data_valid <= 1'b0;

      if (((state == SETUP) || (state == SHIFT)) && !div_done) div_cnt <= div_cnt + 1'b1;
      else                                                     div_cnt <= '0;

      if ((state == GAP) && !gap_done) gap_cnt <= gap_cnt + 1'b1;
      else                             gap_cnt <= '0;

      // The mask is latched here; later ch_mask activity never reaches the scan.
      if (accept) begin
        tx_sr       <= frame_cmd(pick_start);
        cur_ch      <= pick_start;
        mask_rem    <= drop_ch(ch_mask, pick_start);
        cur_nop     <= 1'b0;
        first_frame <= 1'b1;
        fall_cnt    <= '0;
        csn         <= 1'b0;
      end

      if (next_frame) begin
        prev_ch     <= cur_ch;
        first_frame <= 1'b0;
        csn         <= 1'b0;
        if (|mask_rem) begin
          tx_sr    <= frame_cmd(pick_rem);
          cur_ch   <= pick_rem;
          mask_rem <= drop_ch(mask_rem, pick_rem);
        end else begin
          tx_sr   <= '0;
          cur_nop <= 1'b1;
        end
      end

      // Only the first DATA_W bits of a frame form the result, so capture stops there.
      if (rise_evt) begin
        sclk  <= 1'b1;
        sdi   <= tx_sr[31];
        tx_sr <= {tx_sr[30:0], 1'b0};
        if (int'(fall_cnt) < DATA_W) rx_sr <= {rx_sr[DATA_W-2:0], sdo};
      end

      if (fall_evt) begin
        sclk     <= 1'b0;
        fall_cnt <= fall_cnt + 1'b1;
      end

      // Frame j carries the conversion commanded in frame j-1.
      if (frame_end) begin
        csn <= 1'b1;
        if (!first_frame) begin
          data_valid <= 1'b1;
          data       <= rx_sr;
          data_ch    <= prev_ch;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ads868x_seq_ctrl.sv
`default_nettype none
// tb_ads868x_seq_ctrl: two sequencer configurations against a behavioural
// ADS868x model, with a queue scoreboard per lane.
module tb_ads868x_seq_ctrl;

  localparam int NL      = 2;
  localparam int TIMEOUT = 6000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start [NL];
  logic [7:0] mask [NL];
  logic [NL-1:0] busy, data_valid, csn, sclk, sdi, sdo;
  logic [NL-1:0][2:0]  data_ch;
  logic [NL-1:0][15:0] data;
  logic [NL-1:0][15:0] frame_cnt;
  logic [NL-1:0][5:0]  bit_cnt;
  logic [15:0] ain [NL][8];

  logic [18:0] exp_res [NL][$];
  logic [31:0] exp_cmd [NL][$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [31:0] sh_out = '0;
    logic [31:0] sh_in  = '0;
    logic [2:0]  sel    = '0;
    logic        sdo_l  = 1'b0;
    int          bits   = 0;
    int          frames = 0;
    logic [31:0] got_cmd [$];
    logic [18:0] e_res;
    logic [31:0] e_cmd;
    logic [31:0] g_cmd;

    assign sdo[i]       = sdo_l;
    assign frame_cnt[i] = 16'(frames);
    assign bit_cnt[i]   = 6'(bits);

    if (i == 0) begin : g_def
      ads868x_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start[i]), .ch_mask(mask[i][3:0]),
        .busy(busy[i]), .data_valid(data_valid[i]), .data_ch(data_ch[i]),
        .data(data[i]), .csn(csn[i]), .sclk(sclk[i]), .sdi(sdi[i]), .sdo(sdo[i])
      );
    end else begin : g_fast
      ads868x_seq_ctrl #(.NUM_CH(8), .DATA_W(16), .SCLK_HALF(1), .CSN_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start[i]), .ch_mask(mask[i]),
        .busy(busy[i]), .data_valid(data_valid[i]), .data_ch(data_ch[i]),
        .data(data[i]), .csn(csn[i]), .sclk(sclk[i]), .sdi(sdi[i]), .sdo(sdo[i])
      );
    end

    // ADC: result of the previously selected channel in the top 16 bits, noise below.
    always @(negedge csn[i]) begin
      sh_out = {ain[i][sel], 16'($urandom)};
      sdo_l  = sh_out[31];
      sh_in  = '0;
      bits   = 0;
    end

    // ADC latches sdi and launches the next sdo bit on the falling sclk edge.
    always @(negedge sclk[i]) begin
      sh_in  = {sh_in[30:0], sdi[i]};
      sh_out = {sh_out[30:0], 1'b0};
      sdo_l  = sh_out[31];
      bits++;
      if (bits == 32) begin
        frames++;
        got_cmd.push_back(sh_in);
        if (sh_in[31:29] == 3'b110) sel = sh_in[28:26];
      end
    end

    always @(negedge clk) begin
      if (data_valid[i] === 1'b1) begin
        checks++;
        if (exp_res[i].size() == 0) begin
          errors++;
          $display("FAIL lane%0d result: got ch=%0d data=%h, expected no result", i, data_ch[i], data[i]);
        end else begin
          e_res = exp_res[i].pop_front();
          if ({data_ch[i], data[i]} !== e_res) begin
            errors++;
            $display("FAIL lane%0d result: got ch=%0d data=%h, expected ch=%0d data=%h",
                     i, data_ch[i], data[i], e_res[18:16], e_res[15:0]);
          end
        end
      end
      while (got_cmd.size() > 0) begin
        g_cmd = got_cmd.pop_front();
        checks++;
        if (exp_cmd[i].size() == 0) begin
          errors++;
          $display("FAIL lane%0d cmd: got %h, expected no frame", i, g_cmd);
        end else begin
          e_cmd = exp_cmd[i].pop_front();
          if (g_cmd !== e_cmd) begin
            errors++;
            $display("FAIL lane%0d cmd: got %h, expected %h", i, g_cmd, e_cmd);
          end
        end
      end
    end
  end

  function automatic logic [31:0] cmd_of(input int ch);
    return 32'hC000_0000 | (32'(ch) << 26);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_start(input int lane, input logic [7:0] m);
    @(posedge clk); #1;
    start[lane] = 1'b1;
    mask[lane]  = m;
    @(posedge clk); #1;
    start[lane] = 1'b0;
    mask[lane]  = 8'($urandom);
  endtask

  task automatic wait_idle(input int lane, input string name);
    int n = 0;
    while (busy[lane] !== 1'b0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%b after %0d cycles, expected 0", name, busy[lane], n);
    end
  endtask

  task automatic begin_scan(input int lane, input logic [7:0] m, input string name,
                            output int f0, output int k);
    int n = (lane == 0) ? 4 : 8;
    k  = 0;
    f0 = int'(frame_cnt[lane]);
    for (int c = 0; c < n; c++) begin
      if (m[c]) begin
        exp_cmd[lane].push_back(cmd_of(c));
        exp_res[lane].push_back({3'(c), ain[lane][c]});
        k++;
      end
    end
    exp_cmd[lane].push_back(32'h0);
    pulse_start(lane, m);
    check({name, " busy_rise"}, 32'(busy[lane]), 32'd1);
  endtask

  task automatic end_scan(input int lane, input string name, input int f0, input int k);
    wait_idle(lane, name);
    repeat (2) @(negedge clk);
    check({name, " frames"}, 32'(int'(frame_cnt[lane]) - f0), 32'(k + 1));
    check({name, " results_left"}, 32'(exp_res[lane].size()), 32'd0);
    check({name, " cmds_left"}, 32'(exp_cmd[lane].size()), 32'd0);
    check({name, " idle_pins"}, {30'd0, csn[lane], sclk[lane]}, 32'd2);
  endtask

  task automatic run_scan(input int lane, input logic [7:0] m, input string name);
    int f0, k;
    begin_scan(lane, m, name, f0, k);
    end_scan(lane, name, f0, k);
  endtask

  task automatic measure_sclk(input int lane, input int half, input string name);
    int n = 0;
    while (sclk[lane] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (sclk[lane] === 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({name, " sclk_high"}, 32'(n), 32'(half));
    n = 0;
    while (sclk[lane] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({name, " sclk_low"}, 32'(n), 32'(half));
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, k, n;
    for (int l = 0; l < NL; l++) begin
      start[l] = 1'b0;
      mask[l]  = 8'h00;
      for (int c = 0; c < 8; c++) ain[l][c] = 16'($urandom);
    end

    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d reset_ctrl", l),
            {27'd0, csn[l], sclk[l], sdi[l], busy[l], data_valid[l]}, 32'h10);
      check($sformatf("lane%0d reset_data", l), {13'd0, data_ch[l], data[l]}, 32'd0);
    end
    rst_n = 1'b1;

    // Single channel, lane 0 with sclk period check.
    ain[0][0] = 16'hCAFE;
    begin_scan(0, 8'h01, "single", f0, k);
    measure_sclk(0, 2, "single");
    end_scan(0, "single", f0, k);

    ain[0][0] = 16'h1111; ain[0][1] = 16'h2222; ain[0][2] = 16'h3333; ain[0][3] = 16'h4444;
    run_scan(0, 8'h0F, "all4");
    run_scan(0, 8'h0A, "odd");

    // Starts that must be ignored.
    f0 = int'(frame_cnt[0]);
    pulse_start(0, 8'h00);
    check("zero_mask busy", 32'(busy[0]), 32'd0);
    repeat (300) @(negedge clk);
    check("zero_mask frames", 32'(int'(frame_cnt[0]) - f0), 32'd0);

    begin_scan(0, 8'h0F, "busy_start", f0, k);
    n = 0;
    while (int'(frame_cnt[0]) - f0 < 2 && n < TIMEOUT) begin @(negedge clk); n++; end
    check("busy_start reach_frame2", 32'(n < TIMEOUT), 32'd1);
    pulse_start(0, 8'h03);
    end_scan(0, "busy_start", f0, k);

    // Reset in the middle of frame 1.
    for (int c = 0; c < 8; c++) ain[0][c] = 16'($urandom);
    begin_scan(0, 8'h0F, "abort", f0, k);
    n = 0;
    while (!(int'(frame_cnt[0]) - f0 == 1 && bit_cnt[0] == 6'd10) && n < TIMEOUT) begin
      @(negedge clk); n++;
    end
    check("abort reach_bit10", 32'(n < TIMEOUT), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort pins", {28'd0, csn[0], sclk[0], busy[0], data_valid[0]}, 32'h8);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_res[0].delete();
    exp_cmd[0].delete();
    run_scan(0, 8'h04, "after_reset");

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) ain[0][c] = 16'($urandom);
      run_scan(0, 8'($urandom_range(1, 15)), $sformatf("rand_a%0d", r));
    end

    // Fast configuration: 8 channels, minimum timing.
    ain[1][7] = 16'($urandom);
    begin_scan(1, 8'h80, "fast_ch7", f0, k);
    measure_sclk(1, 1, "fast_ch7");
    end_scan(1, "fast_ch7", f0, k);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) ain[1][c] = 16'($urandom);
      run_scan(1, 8'($urandom_range(1, 255)), $sformatf("rand_b%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
